multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Multi-cycle control state machine for the RV32I-subset Fibonacci core. Sequences fetch/decode/execute/memory/writeback for each instruction.
- Sits directly upstream of the program counter: generates pc_write and pc_sel, which the PC consumes together with the ALU zero flag.
- Also drives instruction-register, register-file, data-memory and ALU-control strobes.

Parameters:
- MEM_WAIT_MAX, 0, max cycles to wait for mem_ready in any memory state. 0 = wait forever. Range 0..255.

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12] (decoded downstream; used only for the illegal check)
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write  out  1  PC update enable
- pc_sel  out  2  00 PC_4, 01 PC_BRANCH, 10 PC_JAL, 11 hold
- ir_write  out  1  latch fetched instruction
- mem_read  out  1  memory read request (fetch or load)
- mem_write  out  1  memory write request (store)
- i_or_d  out  1  0 = address from pc, 1 = address from ALU result
- reg_write  out  1  register-file write enable
- wb_sel  out  2  00 ALU, 01 memory data, 10 pc+4
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 ADD, 01 SUB, 10 use funct fields
- halted  out  1  core stopped
- bus_err  out  1  memory timeout occurred (sticky)
- illegal  out  1  unsupported opcode/funct3 decoded (sticky)
- instret  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset:
  - State goes to FETCH. halted/bus_err/illegal = 0, wait counter = 0.
  - While arst_n is low, every strobe is 0 and pc_sel = 11.
  - Reset mid-instruction aborts it: no pc_write, reg_write or mem_write is issued.
- Default outputs in every state: all strobes 0, pc_sel = 11, wb_sel = 00, alu_src_b = 0, alu_op = 00, i_or_d = 0.
- FETCH: mem_read = 1, i_or_d = 0.
  - mem_ready = 1: ir_write = 1 (combinational on mem_ready) -> DECODE.
  - Otherwise stay.
- DECODE (1 cycle), branch on opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 (funct3 = 010) -> MEM_ADDR
  - 0100011 (funct3 = 010) -> MEM_ADDR
  - 1100011 (funct3 = 000) -> BRANCH
  - 1101111 -> JAL
  - 1110011 -> HALT
  - Anything else -> HALT with illegal = 1.
- EXEC_R: alu_op = 10, alu_src_b = 0 -> ALU_WB.
- EXEC_I: alu_op = 10, alu_src_b = 1 -> ALU_WB.
- ALU_WB: reg_write = 1, wb_sel = 00, pc_write = 1, pc_sel = 00 -> FETCH. ALU control inputs are held from the previous state.
- MEM_ADDR: alu_op = 00, alu_src_b = 1 -> MEM_RD (load) or MEM_WR (store).
- MEM_RD: mem_read = 1, i_or_d = 1; address controls held.
  - On mem_ready -> MEM_WB.
- MEM_WB: reg_write = 1, wb_sel = 01, pc_write = 1, pc_sel = 00 -> FETCH.
- MEM_WR: mem_write = 1, i_or_d = 1.
  - On mem_ready: pc_write = 1, pc_sel = 00 -> FETCH.
- BRANCH: alu_op = 01, alu_src_b = 0, pc_write = 1, pc_sel = 01 -> FETCH. The taken/not-taken choice is made by the PC from zero in this same cycle.
- JAL: reg_write = 1, wb_sel = 10, pc_write = 1, pc_sel = 10 -> FETCH.
- HALT: halted = 1, all strobes 0; terminal until reset.
- pc_write invariant: asserted exactly one cycle per retired instruction, never in FETCH/DECODE/HALT.
- Instruction latency in cycles with mem_ready = 1 immediately:
  - ALU: 4
  - Load: 5
  - Store: 4
  - Branch: 3
  - JAL: 3
  - Each wait cycle on mem_ready adds 1.
- Timeout, MEM_WAIT_MAX = N > 0:
  - The wait counter increments each cycle in FETCH/MEM_RD/MEM_WR while mem_ready = 0, and clears on state change.
  - When the count reaches N with mem_ready still 0: next state is HALT, bus_err = 1, and no strobe completes.
  - mem_ready arriving in the same cycle the count reaches N wins: the access completes normally.
- The wait counter saturates and never wraps.

Optional Feature:
- Macro: CTRL_INSTRET_EN.
- Defined:
  - instret is a 32-bit counter, reset 0, incremented in every cycle with pc_write = 1.
  - Wraps FFFF_FFFF -> 0000_0000.
  - Frozen in HALT.
- Undefined: instret is tied to 0 and no counter flops are generated.

Test Plan:
- ADD (opcode 0110011), mem_ready tied 1 -> states FETCH, DECODE, EXEC_R, ALU_WB. reg_write = 1 and pc_write = 1 with pc_sel = 00 in cycle 4 only. instret = 1.
- LW (0000011, funct3 010), mem_ready low 3 cycles in MEM_RD -> mem_read and i_or_d held high 4 cycles. MEM_WB then gives reg_write = 1 with wb_sel = 01. Total 8 cycles.
- BEQ (1100011, funct3 000) -> BRANCH on cycle 3 with pc_write = 1, pc_sel = 01, alu_op = 01. Exactly one pc_write.
- MEM_WAIT_MAX = 4, mem_ready held 0 in FETCH -> HALT after 4 wait cycles. bus_err = 1, halted = 1, no ir_write, all strobes 0 thereafter.
- Opcode 0000000 -> HALT with illegal = 1. Then pulse arst_n low mid-HALT -> FETCH next cycle, flags cleared, instret = 0.
- CTRL_INSTRET_EN defined, instret preloaded via force to FFFF_FFFF, one JAL -> instret = 0000_0000 and reg_write/wb_sel = 10 in that cycle.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle controller (master) and the datapath/memory side (slave).
interface multicycle_control_fsm_if;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        mem_ready;
  logic        pc_write;
  logic [1:0]  pc_sel;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        i_or_d;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        alu_src_b;
  logic [1:0]  alu_op;
  logic        halted;
  logic        bus_err;
  logic        illegal;
  logic [31:0] instret;

  modport master (
    input  opcode, funct3, mem_ready,
    output pc_write, pc_sel, ir_write, mem_read, mem_write, i_or_d, reg_write,
           wb_sel, alu_src_b, alu_op, halted, bus_err, illegal, instret
  );

  modport slave (
    output opcode, funct3, mem_ready,
    input  pc_write, pc_sel, ir_write, mem_read, mem_write, i_or_d, reg_write,
           wb_sel, alu_src_b, alu_op, halted, bus_err, illegal, instret
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle fetch/decode/execute/memory/writeback controller for the RV32I-subset Fibonacci core.
// Define CTRL_INSTRET_EN to build the retired-instruction counter; otherwise instret reads 0.
module multicycle_control_fsm #(
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic                     clk,
  input  logic                     arst_n,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [7:0] WAIT_MAX  = 8'(MEM_WAIT_MAX);

  state_t     r_state;
  logic [7:0] r_wait;
  logic       r_pc_write;
  logic [1:0] r_pc_sel;
  logic       r_mem_read;
  logic       r_mem_write;
  logic       r_i_or_d;
  logic       r_reg_write;
  logic [1:0] r_wb_sel;
  logic       r_alu_src_b;
  logic [1:0] r_alu_op;
  logic       r_halted;
  logic       r_bus_err;
  logic       r_illegal;

  state_t     w_next;
  logic       w_waiting;
  logic       w_timeout;
  logic       w_illegal_op;
  logic       w_wr_done;
  logic [7:0] w_wait_inc;

  // Next-state decode; a timeout only fires when mem_ready is still low as the count reaches the limit
  always_comb begin
    w_next       = r_state;
    w_illegal_op = 1'b0;
    w_waiting    = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    w_wait_inc   = (r_wait == 8'hFF) ? r_wait : r_wait + 8'd1;
    if ((WAIT_MAX != 8'd0) && w_waiting && !bus.mem_ready) begin
      w_timeout = (w_wait_inc == WAIT_MAX);
    end else begin
      w_timeout = 1'b0;
    end
    case (r_state)
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (bus.mem_ready) begin
          if (r_state == S_FETCH) begin
            w_next = S_DECODE;
          end else if (r_state == S_MEM_RD) begin
            w_next = S_MEM_WB;
          end else begin
            w_next = S_FETCH;
          end
        end else if (w_timeout) begin
          w_next = S_HALT;
        end else begin
          w_next = r_state;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_R:      w_next = S_EXEC_R;
          OP_I:      w_next = S_EXEC_I;
          OP_LOAD, OP_STORE: begin
            if (bus.funct3 == 3'b010) begin
              w_next = S_MEM_ADDR;
            end else begin
              w_next       = S_HALT;
              w_illegal_op = 1'b1;
            end
          end
          OP_BRANCH: begin
            if (bus.funct3 == 3'b000) begin
              w_next = S_BRANCH;
            end else begin
              w_next       = S_HALT;
              w_illegal_op = 1'b1;
            end
          end
          OP_JAL:    w_next = S_JAL;
          OP_SYSTEM: w_next = S_HALT;
          default: begin
            w_next       = S_HALT;
            w_illegal_op = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
      S_MEM_ADDR: begin
        if (bus.opcode == OP_STORE) begin
          w_next = S_MEM_WR;
        end else begin
          w_next = S_MEM_RD;
        end
      end
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL: w_next = S_FETCH;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
  end

  // State, wait counter, sticky flags and outputs registered from the state being entered
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= S_FETCH;
      r_wait      <= 8'd0;
      r_pc_write  <= 1'b0;
      r_pc_sel    <= 2'b11;
      r_mem_read  <= 1'b1;
      r_mem_write <= 1'b0;
      r_i_or_d    <= 1'b0;
      r_reg_write <= 1'b0;
      r_wb_sel    <= 2'b00;
      r_alu_src_b <= 1'b0;
      r_alu_op    <= 2'b00;
      r_halted    <= 1'b0;
      r_bus_err   <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_halted  <= r_halted | (w_next == S_HALT);
      r_bus_err <= r_bus_err | w_timeout;
      r_illegal <= r_illegal | w_illegal_op;
      if (w_next != r_state) begin
        r_wait <= 8'd0;
      end else if (w_waiting && !bus.mem_ready) begin
        r_wait <= w_wait_inc;
      end else begin
        r_wait <= r_wait;
      end

      r_pc_write  <= 1'b0;
      r_pc_sel    <= 2'b11;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_i_or_d    <= 1'b0;
      r_reg_write <= 1'b0;
      r_wb_sel    <= 2'b00;
      r_alu_src_b <= 1'b0;
      r_alu_op    <= 2'b00;
      // ALU_WB and the memory states keep the ALU controls so the result/address stays stable
      case (w_next)
        S_FETCH:  r_mem_read <= 1'b1;
        S_EXEC_R: r_alu_op   <= 2'b10;
        S_EXEC_I: begin
          r_alu_op    <= 2'b10;
          r_alu_src_b <= 1'b1;
        end
        S_ALU_WB: begin
          r_reg_write <= 1'b1;
          r_pc_write  <= 1'b1;
          r_pc_sel    <= 2'b00;
          r_alu_op    <= r_alu_op;
          r_alu_src_b <= r_alu_src_b;
        end
        S_MEM_ADDR: r_alu_src_b <= 1'b1;
        S_MEM_RD: begin
          r_mem_read  <= 1'b1;
          r_i_or_d    <= 1'b1;
          r_alu_op    <= r_alu_op;
          r_alu_src_b <= r_alu_src_b;
        end
        S_MEM_WR: begin
          r_mem_write <= 1'b1;
          r_i_or_d    <= 1'b1;
          r_alu_op    <= r_alu_op;
          r_alu_src_b <= r_alu_src_b;
        end
        S_MEM_WB: begin
          r_reg_write <= 1'b1;
          r_wb_sel    <= 2'b01;
          r_pc_write  <= 1'b1;
          r_pc_sel    <= 2'b00;
        end
        S_BRANCH: begin
          r_alu_op   <= 2'b01;
          r_pc_write <= 1'b1;
          r_pc_sel   <= 2'b01;
        end
        S_JAL: begin
          r_reg_write <= 1'b1;
          r_wb_sel    <= 2'b10;
          r_pc_write  <= 1'b1;
          r_pc_sel    <= 2'b10;
        end
        default: r_pc_sel <= 2'b11;
      endcase
    end
  end

  // Reset values model FETCH, so the fetch strobes are masked while arst_n is low
  assign w_wr_done     = (r_state == S_MEM_WR) & bus.mem_ready;
  assign bus.ir_write  = arst_n & (r_state == S_FETCH) & bus.mem_ready;
  assign bus.mem_read  = arst_n & r_mem_read;
  assign bus.pc_write  = r_pc_write | w_wr_done;
  assign bus.pc_sel    = w_wr_done ? 2'b00 : r_pc_sel;
  assign bus.mem_write = r_mem_write;
  assign bus.i_or_d    = r_i_or_d;
  assign bus.reg_write = r_reg_write;
  assign bus.wb_sel    = r_wb_sel;
  assign bus.alu_src_b = r_alu_src_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.halted    = r_halted;
  assign bus.bus_err   = r_bus_err;
  assign bus.illegal   = r_illegal;

`ifdef CTRL_INSTRET_EN
  logic [31:0] r_instret;

  // Retired-instruction counter; wraps naturally and is frozen in HALT since no pc_write occurs there
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_instret <= 32'd0;
    end else if (bus.pc_write) begin
      r_instret <= r_instret + 32'd1;
    end else begin
      r_instret <= r_instret;
    end
  end

  assign bus.instret = r_instret;
`else
  assign bus.instret = 32'd0;
`endif

endmodule
